fetch_unit: RTL and testbench

// - Instruction fetch stage; sits directly upstream of the branch unit and decode.
// - Owns the fetch PC and issues word reads on the instruction-memory request/response port.
// - Buffers returned words with their PC in a small FIFO; presents them downstream as instruction + program_counter.
// - Consumes the branch unit's load_new_program_counter/new_program_counter to redirect and flush.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/fetch_fifo.sv | 65 ++++++
 rtl/fetch_unit.sv | 188 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction fetch path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_pkg;

   localparam int XLEN        = 32;
   localparam int INSTR_BYTES = 4;

   typedef enum logic [1:0] {
      FETCH     = 2'd0,
      WAIT_RESP = 2'd1,
      FAULT     = 2'd2
   } fetch_state_t;

   // One buffered fetch result: the address it came from and the word itself.
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] insn;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Generic registered FIFO (power-of-2 depth) with synchronous flush and occupancy out.
// Latency: a push is visible at the head one cycle later; push and pop may share a cycle.
// Backpressure: push when full is dropped unless a pop frees a slot; the writer must use count.
module fetch_fifo #(
   parameter int  DEPTH = 2,
   parameter int  WIDTH = 64,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop,
   input  logic             flush,
   output logic [WIDTH-1:0] head_dat,
   output logic             empty,
   output logic [CW-1:0]    count
);

   localparam int            AW   = $clog2(DEPTH);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    cnt;
   logic             do_pop;
   logic             do_push;

   // Pop only real entries; a push into a full FIFO is allowed only when a pop frees the slot.
   always_comb begin
      do_pop  = pop && (cnt != '0);
      do_push = push && ((cnt != FULL) || do_pop);
   end

   // Storage and pointers; flush discards everything, including a same-cycle push.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_dat;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         cnt <= cnt + CW'(do_push) - CW'(do_pop);
      end
   end

   assign head_dat = mem[rd_ptr];
   assign empty    = (cnt == '0);
   assign count    = cnt;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the fetch PC, issues one imem read at a time, buffers words with their PC.
// Latency: response to instr_valid is 1 cycle (registered buffer); first request 1 cycle after reset release.
// Backpressure: requests issue only while buffer credit remains; instr_ready pops the head.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
   parameter int              FIFO_DEPTH   = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_resp_valid,
   input  logic [XLEN-1:0] imem_resp_data,
   input  logic            imem_resp_err,
   input  logic            load_new_program_counter,
   input  logic [XLEN-1:0] new_program_counter,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [XLEN-1:0] instruction,
   output logic [XLEN-1:0] program_counter,
   output logic            fetch_fault,
   output logic [XLEN-1:0] fault_addr
);

   localparam int            CW         = $clog2(FIFO_DEPTH + 1);
   localparam logic [CW-1:0] FIFO_LIMIT = CW'(FIFO_DEPTH);

   fetch_state_t    state_q, state_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
   logic [XLEN-1:0] pend_pc_q, pend_pc_d;
   logic [XLEN-1:0] fault_addr_q, fault_addr_d;
   logic            pend_q, pend_d;
   logic            drop_q, drop_d;
   logic            run_q;

   logic            accept;
   logic            misaligned;
   logic            push;
   logic            flush;
   logic            fifo_empty;
   logic [CW-1:0]   fifo_count;
   fetch_entry_t    push_entry;
   fetch_entry_t    head_entry;

   // Only one request is ever outstanding, so in FETCH the credit check reduces to buffer occupancy.
   // run_q keeps req_valid low while reset is held and for the first cycle after release.
   assign imem_req_valid = run_q && (state_q == FETCH) && (fifo_count < FIFO_LIMIT);
   assign imem_addr      = fetch_pc_q;
   assign accept         = imem_req_valid && imem_req_ready;
   assign misaligned     = (new_program_counter[1:0] != 2'b00);

   // Next-state, PC, drop and fault bookkeeping.
   always_comb begin
      state_d       = state_q;
      fetch_pc_d    = fetch_pc_q;
      inflight_pc_d = inflight_pc_q;
      pend_pc_d     = pend_pc_q;
      fault_addr_d  = fault_addr_q;
      pend_d        = pend_q;
      drop_d        = drop_q;
      push          = 1'b0;
      flush         = 1'b0;

      case (state_q)
         FETCH: begin
            if (load_new_program_counter) begin
               flush = 1'b1;
               if (misaligned) begin
                  state_d      = FAULT;
                  fault_addr_d = new_program_counter;
                  pend_d       = 1'b0;
               end else if (accept) begin
                  // Request goes out this cycle but is already stale.
                  inflight_pc_d = fetch_pc_q;
                  fetch_pc_d    = new_program_counter;
                  drop_d        = 1'b1;
                  pend_d        = 1'b0;
                  state_d       = WAIT_RESP;
               end else if (imem_req_valid) begin
                  // A presented request must stay stable; park the target until it is taken.
                  pend_d    = 1'b1;
                  pend_pc_d = new_program_counter;
               end else begin
                  fetch_pc_d = new_program_counter;
               end
            end else if (accept) begin
               inflight_pc_d = fetch_pc_q;
               state_d       = WAIT_RESP;
               if (pend_q) begin
                  fetch_pc_d = pend_pc_q;
                  drop_d     = 1'b1;
                  pend_d     = 1'b0;
               end else begin
                  fetch_pc_d = fetch_pc_q + XLEN'(INSTR_BYTES);
               end
            end
         end

         WAIT_RESP: begin
            if (load_new_program_counter) begin
               flush = 1'b1;
               if (misaligned) begin
                  state_d      = FAULT;
                  fault_addr_d = new_program_counter;
               end else begin
                  fetch_pc_d = new_program_counter;
                  if (imem_resp_valid) begin
                     // The arriving response is the stale one; it is discarded here, so nothing is left to drop.
                     drop_d  = 1'b0;
                     state_d = FETCH;
                  end else begin
                     drop_d = 1'b1;
                  end
               end
            end else if (imem_resp_valid) begin
               state_d = FETCH;
               if (drop_q) begin
                  drop_d = 1'b0;
               end else if (imem_resp_err) begin
                  state_d      = FAULT;
                  fault_addr_d = inflight_pc_q;
               end else begin
                  push = 1'b1;
               end
            end
         end

         FAULT: begin
            // Terminal until reset; redirects and late responses are ignored.
         end

         default: begin
            state_d = FAULT;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= FETCH;
         fetch_pc_q    <= RESET_VECTOR;
         inflight_pc_q <= '0;
         pend_pc_q     <= '0;
         fault_addr_q  <= '0;
         pend_q        <= 1'b0;
         drop_q        <= 1'b0;
         run_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         inflight_pc_q <= inflight_pc_d;
         pend_pc_q     <= pend_pc_d;
         fault_addr_q  <= fault_addr_d;
         pend_q        <= pend_d;
         drop_q        <= drop_d;
         run_q         <= 1'b1;
      end
   end

   assign push_entry = '{pc: inflight_pc_q, insn: imem_resp_data};

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(fetch_entry_t))
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push),
      .push_dat (push_entry),
      .pop      (instr_valid && instr_ready),
      .flush    (flush),
      .head_dat (head_entry),
      .empty    (fifo_empty),
      .count    (fifo_count)
   );

   assign instr_valid     = !fifo_empty;
   assign instruction     = head_entry.insn;
   assign program_counter = head_entry.pc;
   assign fetch_fault     = (state_q == FAULT);
   assign fault_addr      = fault_addr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: table-driven fill/drain trace plus redirect, fault and wrap sequences.
// Inputs change just after the falling edge; outputs are sampled at the falling edge.
// A small in-bench memory model answers accepted requests after mem_lat cycles.
module tb_fetch_unit;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   // Main DUT (reset vector 0)
   logic        rst_n;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_resp_valid, imem_resp_err;
   logic [31:0] imem_resp_data;
   logic        load_new_program_counter;
   logic [31:0] new_program_counter;
   logic        instr_valid, instr_ready;
   logic [31:0] instruction, program_counter;
   logic        fetch_fault;
   logic [31:0] fault_addr;

   // Wrap DUT (reset vector at top of address space)
   logic        rst_n_b;
   logic        req_valid_b, req_ready_b;
   logic [31:0] addr_b;
   logic        resp_valid_b, resp_err_b;
   logic [31:0] resp_data_b;
   logic        load_b;
   logic [31:0] npc_b;
   logic        iv_b, ir_b;
   logic [31:0] insn_b, pc_b;
   logic        fault_b;
   logic [31:0] fault_addr_b;

   fetch_unit #(.RESET_VECTOR(32'h0000_0000), .FIFO_DEPTH(2)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
      .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data), .imem_resp_err(imem_resp_err),
      .load_new_program_counter(load_new_program_counter), .new_program_counter(new_program_counter),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instruction(instruction), .program_counter(program_counter),
      .fetch_fault(fetch_fault), .fault_addr(fault_addr)
   );

   fetch_unit #(.RESET_VECTOR(32'hFFFF_FFFC), .FIFO_DEPTH(2)) u_wrap (
      .clk(clk), .rst_n(rst_n_b),
      .imem_req_valid(req_valid_b), .imem_req_ready(req_ready_b), .imem_addr(addr_b),
      .imem_resp_valid(resp_valid_b), .imem_resp_data(resp_data_b), .imem_resp_err(resp_err_b),
      .load_new_program_counter(load_b), .new_program_counter(npc_b),
      .instr_valid(iv_b), .instr_ready(ir_b),
      .instruction(insn_b), .program_counter(pc_b),
      .fetch_fault(fault_b), .fault_addr(fault_addr_b)
   );

   int n_chk  = 0;
   int n_pass = 0;

   // Memory model state
   bit          mem_ready;
   int          mem_lat;
   bit          busy;
   int          cnt;
   logic [31:0] mem_addr_q;
   bit          err_en;
   logic [31:0] err_addr;
   logic [31:0] issued[$];
   logic [31:0] pop_pc[$];

   typedef struct {
      bit          ir;
      bit          e_rv;
      logic [31:0] e_addr;
      bit          e_iv;
      logic [31:0] e_pc;
   } vec_t;
   vec_t vt[10];

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return a ^ 32'h1300_0013;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // One clock: log what the coming rising edge consumes, then drive the model for the next edge.
   task automatic tick();
      bit          acc;
      logic [31:0] a;
      acc = imem_req_valid && imem_req_ready;
      a   = imem_addr;
      if (acc) issued.push_back(a);
      if (instr_valid && instr_ready) pop_pc.push_back(program_counter);
      @(posedge clk);
      @(negedge clk);
      imem_resp_valid = 1'b0;
      imem_resp_err   = 1'b0;
      imem_resp_data  = '0;
      if (acc) begin
         busy       = 1'b1;
         cnt        = mem_lat;
         mem_addr_q = a;
      end
      if (busy) begin
         if (cnt <= 1) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = word_at(mem_addr_q);
            imem_resp_err   = err_en && (mem_addr_q == err_addr);
            busy            = 1'b0;
         end else begin
            cnt--;
         end
      end
      imem_req_ready = mem_ready;
   endtask

   task automatic set_ready(input bit r);
      mem_ready      = r;
      imem_req_ready = r;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      load_new_program_counter = 1'b0;
      instr_ready     = 1'b0;
      busy            = 1'b0;
      cnt             = 0;
      imem_resp_valid = 1'b0;
      imem_resp_err   = 1'b0;
      err_en          = 1'b0;
      tick();
      tick();
      issued.delete();
      pop_pc.delete();
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      int n;
      int seen;

      vt[0] = '{0, 1, 32'h00, 0, 32'h0};
      vt[1] = '{0, 0, 32'h04, 0, 32'h0};
      vt[2] = '{0, 1, 32'h04, 1, 32'h0};
      vt[3] = '{0, 0, 32'h08, 1, 32'h0};
      vt[4] = '{0, 0, 32'h08, 1, 32'h0};
      vt[5] = '{0, 0, 32'h08, 1, 32'h0};
      vt[6] = '{1, 1, 32'h08, 1, 32'h4};
      vt[7] = '{1, 0, 32'h0C, 0, 32'h0};
      vt[8] = '{1, 1, 32'h0C, 1, 32'h8};
      vt[9] = '{0, 0, 32'h10, 1, 32'h8};

      rst_n = 1'b0; rst_n_b = 1'b0;
      load_new_program_counter = 1'b0; new_program_counter = '0;
      instr_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_err = 1'b0; imem_resp_data = '0;
      mem_lat = 1; err_en = 1'b0; err_addr = '0; busy = 1'b0; cnt = 0;
      set_ready(1'b1);
      req_ready_b = 1'b1; resp_valid_b = 1'b0; resp_err_b = 1'b0; resp_data_b = '0;
      load_b = 1'b0; npc_b = '0; ir_b = 1'b0;
      tick();
      tick();

      // Reset values
      chk("rst_req_valid", imem_req_valid, 0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_instr_valid", instr_valid, 0);
      chk("rst_fault", fetch_fault, 0);
      chk("rst_fault_addr", fault_addr, 0);
      chk("rst_instruction", instruction, 0);
      chk("rst_pc", program_counter, 0);
      chk("rst_wrap_addr", addr_b, 32'hFFFF_FFFC);
      chk("rst_wrap_req_valid", req_valid_b, 0);

      // Fill with instr_ready low, then drain
      do_reset();
      for (int i = 0; i < 10; i++) begin
         instr_ready = vt[i].ir;
         tick();
         chk($sformatf("v%0d_req_valid", i), imem_req_valid, vt[i].e_rv);
         chk($sformatf("v%0d_addr", i), imem_addr, vt[i].e_addr);
         chk($sformatf("v%0d_instr_valid", i), instr_valid, vt[i].e_iv);
         if (vt[i].e_iv) begin
            chk($sformatf("v%0d_pc", i), program_counter, vt[i].e_pc);
            chk($sformatf("v%0d_insn", i), instruction, word_at(vt[i].e_pc));
         end
      end
      chk("fill_issued_n", issued.size(), 4);
      for (int i = 0; i < 3; i++) chk($sformatf("fill_issued%0d", i), issued[i], 32'(i * 4));
      chk("fill_pops_n", pop_pc.size(), 2);
      chk("fill_pop0", pop_pc[0], 32'h0);
      chk("fill_pop1", pop_pc[1], 32'h4);

      // Redirect to 0x100 while the 0x8 request is outstanding (3-cycle memory)
      do_reset();
      mem_lat = 3;
      instr_ready = 1'b1;
      t = 0;
      while (issued.size() < 3 && t < 60) begin tick(); t++; end
      chk("redir_reached_0x8", issued.size(), 3);
      instr_ready = 1'b0;
      load_new_program_counter = 1'b1; new_program_counter = 32'h100;
      tick();
      load_new_program_counter = 1'b0;
      chk("redir_addr", imem_addr, 32'h100);
      chk("redir_no_req_while_wait", imem_req_valid, 0);
      chk("redir_flushed", instr_valid, 0);
      t = 0;
      while (!instr_valid && t < 40) begin tick(); t++; end
      chk("redir_pc", program_counter, 32'h100);
      chk("redir_insn", instruction, word_at(32'h100));
      chk("redir_issued", issued[3], 32'h100);
      chk("redir_pops_n", pop_pc.size(), 2);

      // Redirect while a request is presented but not accepted
      do_reset();
      mem_lat = 1;
      set_ready(1'b0);
      tick();
      load_new_program_counter = 1'b1; new_program_counter = 32'h300;
      tick();
      load_new_program_counter = 1'b0;
      chk("pend_held_valid", imem_req_valid, 1);
      chk("pend_held_addr", imem_addr, 32'h0);
      set_ready(1'b1);
      tick();
      chk("pend_next_addr", imem_addr, 32'h300);
      t = 0;
      while (!instr_valid && t < 20) begin tick(); t++; end
      chk("pend_first_pc", program_counter, 32'h300);
      chk("pend_issued0", issued[0], 32'h0);
      chk("pend_issued1", issued[1], 32'h300);

      // Misaligned redirect faults; a later redirect is ignored
      load_new_program_counter = 1'b1; new_program_counter = 32'h102;
      tick();
      load_new_program_counter = 1'b0;
      chk("mis_fault", fetch_fault, 1);
      chk("mis_fault_addr", fault_addr, 32'h102);
      chk("mis_flushed", instr_valid, 0);
      chk("mis_no_req", imem_req_valid, 0);
      n = issued.size();
      load_new_program_counter = 1'b1; new_program_counter = 32'h200;
      tick();
      load_new_program_counter = 1'b0;
      repeat (4) tick();
      chk("mis_still_fault", fetch_fault, 1);
      chk("mis_addr_kept", fault_addr, 32'h102);
      chk("mis_no_new_issue", issued.size(), n);

      // Access fault on the word at 0x40
      do_reset();
      err_en = 1'b1; err_addr = 32'h40;
      instr_ready = 1'b1;
      t = 0;
      while (!fetch_fault && t < 200) begin tick(); t++; end
      chk("err_fault", fetch_fault, 1);
      chk("err_fault_addr", fault_addr, 32'h40);
      n = issued.size();
      repeat (4) tick();
      err_en = 1'b0;
      chk("err_no_new_issue", issued.size(), n);
      chk("err_last_issue", issued[n-1], 32'h40);
      chk("err_no_instr", instr_valid, 0);
      seen = 0;
      foreach (pop_pc[k]) if (pop_pc[k] == 32'h40) seen++;
      chk("err_0x40_not_delivered", seen, 0);
      chk("err_last_pop", pop_pc[pop_pc.size()-1], 32'h3C);

      // PC wrap and asynchronous reset during WAIT_RESP
      rst_n_b = 1'b1;
      tick();
      chk("wrap_first_valid", req_valid_b, 1);
      chk("wrap_first_addr", addr_b, 32'hFFFF_FFFC);
      tick();
      chk("wrap_waiting", req_valid_b, 0);
      resp_valid_b = 1'b1; resp_data_b = word_at(32'hFFFF_FFFC);
      tick();
      resp_valid_b = 1'b0;
      chk("wrap_second_valid", req_valid_b, 1);
      chk("wrap_second_addr", addr_b, 32'h0);
      chk("wrap_head_pc", pc_b, 32'hFFFF_FFFC);
      tick();
      chk("wrap_wait_addr", addr_b, 32'h4);
      #2;
      rst_n_b = 1'b0;
      #1;
      chk("arst_req_valid", req_valid_b, 0);
      chk("arst_addr", addr_b, 32'hFFFF_FFFC);
      chk("arst_instr_valid", iv_b, 0);
      chk("arst_pc", pc_b, 0);
      tick();
      rst_n_b = 1'b1;
      tick();
      chk("arst_restart_valid", req_valid_b, 1);
      chk("arst_restart_addr", addr_b, 32'hFFFF_FFFC);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
